rpsc_fault_card: RTL

RPSC_FAULT_CARD -- requirements
Module: rpsc_fault_card

---
 rtl/rpsc_fault_card.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rpsc_fault_card.sv
// rpsc_fault_card: multi-channel fault qualification card.
// Raw fault inputs are synchronized and then debounced per channel. Qualified
// rising faults on enabled channels set a sticky alarm latch. A first-fault
// record keeps the lowest channel that latched first. trip_out is the OR of
// the latched alarms selected by TRIP_MASK.
module rpsc_fault_card #(
  parameter int              N_CH      = 8,
  parameter int              DEBOUNCE  = 4,
  parameter logic [N_CH-1:0] TRIP_MASK = '1,
  localparam int             CW        = $clog2(DEBOUNCE + 1),
  localparam int             IDW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] fault_in,
  input  logic [N_CH-1:0] ch_enable,
  input  logic            clear,
  output logic [N_CH-1:0] fault_out,
  output logic [N_CH-1:0] fault_la,
  output logic            trip_out,
  output logic            first_valid,
  output logic [IDW-1:0]  first_id
);

  // The counter hits this value on the last mismatching edge before a toggle.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] fo_q;
  logic [N_CH-1:0] fo_d;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] set_vec;
  logic [N_CH-1:0] la_q;
  logic [N_CH-1:0] la_d;
  logic            fv_q;
  logic            fv_d;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  id_d;
  logic [IDW-1:0]  id_low;

  // Two-flop synchronizer for the asynchronous raw fault inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= fault_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatch edges; toggle the live status when
  // the mismatch has persisted for DEBOUNCE edges, restart on any agreement.
  always_comb begin
    fo_d = fo_q;
    rise = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == fo_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = '0;
        fo_d[i]  = ~fo_q[i];
        rise[i]  = ~fo_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Register the debounce counters and the live fault status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      fo_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      fo_q <= fo_d;
    end
  end

  // Alarm latch: a qualified rise on an enabled channel sets, and a clear only
  // releases channels whose live status is low; the set term wins over clear.
  always_comb begin
    set_vec = rise & ch_enable;
    la_d    = set_vec | (la_q & ~({N_CH{clear}} & ~fo_q));
  end

  // First-fault record: capture the lowest newly set channel when empty, hold
  // while valid, and drop the valid flag once a clear empties every latch.
  always_comb begin
    id_low = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (set_vec[i]) begin
        id_low = IDW'(i);
      end
    end
    fv_d = fv_q;
    id_d = id_q;
    if (!fv_q) begin
      if (|set_vec) begin
        fv_d = 1'b1;
        id_d = id_low;
      end
    end else if (clear && (la_d == '0)) begin
      fv_d = 1'b0;
    end
  end

  // Register the alarm latches and the first-fault record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      la_q <= '0;
      fv_q <= 1'b0;
      id_q <= '0;
    end else begin
      la_q <= la_d;
      fv_q <= fv_d;
      id_q <= id_d;
    end
  end

  assign fault_out   = fo_q;
  assign fault_la    = la_q;
  assign trip_out    = |(la_q & TRIP_MASK);
  assign first_valid = fv_q;
  assign first_id    = id_q;

endmodule
